teclado_fifo: RTL and testbench
===============================

# teclado_fifo

Buffers key codes from the 4x4 matrix-keypad scanner so the SoC never misses a key press. It consumes the scanner's 7-bit `ascii` code and its `isDone` strobe. Those signals come from logic clocked by a divided clock, so this block treats them as asynchronous to `clk50`. Each press is debounced into exactly one entry in a first-word-fall-through FIFO, which the CSR/firmware side drains with a pop strobe.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of 2, minimum 2.
- `ADDR_W`, 3: equals log2(`DEPTH`).
- `DEB_CYCLES`, 4: number of consecutive `clk50` cycles the synchronized `isDone` must stay high before a push; minimum 1.

Ports:
- `clk50` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ascii` in 7: key code from the keypad scanner; asynchronous.
- `isDone` in 1: scanner "key recognized" level; high while the key is held; asynchronous.
- `rd_en` in 1: pop the head entry; ignored when `empty`.
- `clr_ovf` in 1: clears the sticky `overflow` flag.
- `dout` out 7: head entry; forced to 0 when `empty`.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: `count` == `DEPTH`.
- `count` out `ADDR_W`+1: number of stored entries, 0..`DEPTH`.
- `overflow` out 1: sticky; set when a press is dropped because the FIFO is full.

## Operation
- **Synchronizers:** `isDone` and `ascii` each pass through two flops, giving `done_s` and `ascii_s`. No logic uses the raw inputs.
- **Debounce FSM (`cnt` counts up to `DEB_CYCLES`-1):**
  - IDLE: if `done_s`=1, go to WAIT with `cnt`=0.
  - WAIT:
    - If `done_s`=0, return to IDLE and discard the press.
    - Else if `cnt`==`DEB_CYCLES`-1, issue a push request with `ascii_s` sampled on this same edge, then go to HELD.
    - Else increment `cnt`.
  - HELD: stay until `done_s`=0, then go to IDLE.
  - Result: exactly one push per press, no auto-repeat.
- **FIFO:**
  - Write pointer, read pointer and `count` are registered. Pointers wrap modulo `DEPTH`.
  - Push and not full: write at the write pointer, advance it.
  - Push and full, no pop: drop the push; set `overflow`.
  - Pop and not empty: advance the read pointer.
  - Push and pop on the same edge, FIFO non-empty (full included): both take effect and `count` is unchanged.
  - Push and pop on the same edge, FIFO empty: the pop is ignored and the push is stored.
  - `empty`, `full` and `dout` are derived from the registered `count` and read pointer. `dout` = `mem[rd_ptr]` when `count`≠0, otherwise 0.
- **Overflow flag:**
  - Set by a dropped push.
  - Cleared by `clr_ovf`.
  - If a drop and `clr_ovf` happen on the same edge, the set wins.
- **Reset:**
  - Pointers, `count`, `cnt`, synchronizer flops and `overflow` go to 0. FSM goes to IDLE.
  - Outputs after the reset edge: `dout`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0.
  - Memory contents are don't-care.
  - A reset mid-press (WAIT or HELD) abandons the press. If `isDone` is still high after reset, it counts as a new press and follows the full debounce sequence.

## Timing
- Let edge 0 be the first edge that samples `isDone`=1. Then:
  - `done_s`=1 after edge 1.
  - FSM enters WAIT at edge 2.
  - Push occurs at edge `DEB_CYCLES`+2 (edge 6 at the default).
  - `empty`, `count` and `dout` reflect the push after that edge.
- A press is accepted only if `isDone` is sampled high on `DEB_CYCLES`+1 consecutive edges (edges 0..`DEB_CYCLES`). A shorter pulse produces no push.
- `ascii` must be stable from edge `DEB_CYCLES` through edge `DEB_CYCLES`+1. The pushed value is `ascii` as sampled at edge `DEB_CYCLES`.
- Pop: `rd_en` high at edge N. After edge N, `dout`, `count` and `empty` show the next entry.
- The FIFO sustains one push and one pop per cycle with no bubbles.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `isDone`=1 → after the reset edge, `empty`=1, `count`=0, `dout`=0 and `overflow`=0. After release, the held key is pushed at edge `DEB_CYCLES`+2 relative to release.
- **Single press:** `ascii`=7'h35, `isDone` high for 20 cycles, then low → exactly one entry; `dout`=7'h35 and `count`=1 at edge 6. Pulse `rd_en` for 1 cycle → `empty`=1, `dout`=0.
- **Glitch:** `isDone` high for 3 cycles (default `DEB_CYCLES`=4) → `count` stays 0. Increase to 5 cycles → one entry.
- **Order and wrap:** 10 presses with codes 0x30..0x39, each followed by a pop → `dout` sequence is 0x30..0x39, proving the pointers wrap past `DEPTH`=8.
- **Overflow:** 9 presses, no pops → `full`=1, `count`=8, `overflow`=1, and the 9th code is absent. Pulse `clr_ovf` → `overflow`=0 while `count` stays 8.
- **Simultaneous push/pop at full:** FIFO full with 0x41..0x48, a 9th press 0x49 whose push edge coincides with `rd_en` → `count`=8, `overflow`=0, `dout`=0x42, and the tail entry is 0x49.

Source files
------------

// File: rtl/teclado_fifo.sv
// Keypad key-code buffer: synchronizes the scanner outputs, debounces each
// press into a single push, and holds codes in a first-word-fall-through FIFO.
module teclado_fifo #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [6:0]        ascii,
  input  logic              isDone,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [6:0]        dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  logic             done_s1_q;
  logic             done_s_q;
  logic [6:0]       ascii_s1_q;
  logic [6:0]       ascii_s_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;

  logic [6:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             do_push;
  logic             do_pop;
  logic             drop;
  logic             not_full;

  // Two-flop synchronizers for the scanner's slow-clock-domain signals
  always_ff @(posedge clk50) begin
    if (rst) begin
      done_s1_q  <= 1'b0;
      done_s_q   <= 1'b0;
      ascii_s1_q <= '0;
      ascii_s_q  <= '0;
    end else begin
      done_s1_q  <= isDone;
      done_s_q   <= done_s1_q;
      ascii_s1_q <= ascii;
      ascii_s_q  <= ascii_s1_q;
    end
  end

  // Debounce state and hold-counter registers
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One push per stable press; HELD blocks auto-repeat until release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done_s_q) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!done_s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          push    = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!done_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Push/pop arbitration; a pop at full frees the slot for a same-edge push
  always_comb begin
    not_full = (count_q != DEPTH_C);
    do_pop   = rd_en && (count_q != '0);
    do_push  = push && (not_full || do_pop);
    drop     = push && !not_full && !do_pop;

    wr_ptr_d = do_push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (drop) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Pointer, occupancy and sticky overflow registers
  always_ff @(posedge clk50) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents need no reset since count gates the output
  always_ff @(posedge clk50) begin
    if (do_push) mem_q[wr_ptr_q] <= ascii_s_q;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign dout     = empty ? 7'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_teclado_fifo.sv
// Bench for teclado_fifo: press-level reference model feeding a queue,
// monitor compares the FIFO outputs against it every cycle.
module tb_teclado_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DEB    = 4;

  logic              clk50 = 1'b0;
  logic              rst = 1'b1;
  logic [6:0]        ascii = 7'h22;
  logic              isDone = 1'b1;
  logic              rd_en = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [6:0]        dout;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  teclado_fifo #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk50(clk50),
    .rst(rst),
    .ascii(ascii),
    .isDone(isDone),
    .rd_en(rd_en),
    .clr_ovf(clr_ovf),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    int unsigned t;
    logic [6:0]  code;
  } pend_t;

  int          tests = 0;
  int          fails = 0;
  bit          started = 0;
  bit          rnd = 0;
  int unsigned cyc = 0;
  int          run = 0;
  bit          exp_ovf = 0;
  logic [6:0]  exp_q[$];
  pend_t       pend[$];
  bit          push_now;
  logic [6:0]  push_code;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: a press whose isDone is sampled high on DEB+1
  // consecutive edges yields a push two edges later with the code seen
  // on the last of those edges; the FIFO itself is just a queue.
  initial begin
    forever begin
      @(posedge clk50);
      cyc++;
      if (rst) begin
        exp_q.delete();
        pend.delete();
        run     = 0;
        exp_ovf = 0;
        started = 1;
      end else begin
        push_now = 0;
        if (pend.size() > 0 && pend[0].t == cyc) begin
          push_now  = 1;
          push_code = pend[0].code;
          void'(pend.pop_front());
        end
        if (isDone) run++;
        else run = 0;
        if (run == DEB + 1) pend.push_back('{cyc + 2, ascii});
        if (push_now && exp_q.size() < DEPTH) begin
          exp_q.push_back(push_code);
        end else if (push_now) begin
          exp_ovf = 1;
        end else if (clr_ovf) begin
          exp_ovf = 0;
        end
        if (push_now && clr_ovf && exp_q.size() == DEPTH && !exp_ovf)
          exp_ovf = 0;
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires the head on a pop
  initial begin
    forever begin
      @(negedge clk50);
      #1;
      if (started) begin
        chk("count", count, exp_q.size());
        chk("empty", empty, exp_q.size() == 0);
        chk("full", full, exp_q.size() == DEPTH);
        chk("overflow", overflow, exp_ovf);
        chk("dout", dout, exp_q.size() > 0 ? exp_q[0] : 7'd0);
        if (rd_en && !rst && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk50);
    if (rnd) begin
      rd_en   = ($urandom_range(0, 3) == 0);
      clr_ovf = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic press(input logic [6:0] code, input int len, input int gap,
                       input int pop_at, input int rst_at);
    tick();
    ascii  = code;
    isDone = 1'b1;
    if (!rnd) rd_en = 1'b0;
    for (int i = 1; i < len; i++) begin
      tick();
      if (!rnd) rd_en = (i == pop_at);
      if (i == rst_at) rst = 1'b1;
      if (i == rst_at + 2) rst = 1'b0;
    end
    tick();
    isDone = 1'b0;
    rst    = 1'b0;
    if (!rnd) rd_en = (len == pop_at);
    for (int i = 0; i < gap; i++) begin
      tick();
      if (!rnd) rd_en = 1'b0;
      ascii = 7'($urandom);
    end
  endtask

  task automatic pop1();
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int len;
    int ra;
    // Reset with a key held: state cleared, key pushed DEB+2 after release
    tick();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < DEB + 2; j++) tick();
    chk("rel_before", count, 0);
    tick();
    chk("rel_count", count, 1);
    chk("rel_dout", dout, 7'h22);
    isDone = 1'b0;
    repeat (5) tick();
    pop1();

    // Single press
    press(7'h35, 20, 4, -1, -1);
    chk("single_count", count, 1);
    chk("single_dout", dout, 7'h35);
    pop1();
    chk("single_empty", empty, 1);
    chk("single_dout0", dout, 0);

    // Glitch rejection, then minimum accepted width
    press(7'h11, DEB - 1, 4, -1, -1);
    chk("glitch_count", count, 0);
    press(7'h12, DEB + 1, 4, -1, -1);
    chk("minpress_count", count, 1);
    chk("minpress_dout", dout, 7'h12);
    pop1();

    // Order and pointer wrap
    for (int k = 0; k < 10; k++) begin
      press(7'(8'h30 + k), 8, 2, -1, -1);
      chk("wrap_dout", dout, 7'(8'h30 + k));
      pop1();
    end

    // Overflow: ninth press dropped
    for (int k = 0; k < 9; k++) press(7'(8'h50 + k), 8, 2, -1, -1);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);
    chk("ovf_keep", count, 8);
    for (int k = 0; k < 8; k++) begin
      chk("ovf_drain", dout, 7'(8'h50 + k));
      pop1();
    end
    chk("ovf_absent", empty, 1);

    // Push and pop on the same edge at full
    for (int k = 0; k < 8; k++) press(7'(8'h41 + k), 8, 2, -1, -1);
    press(7'h49, 12, 4, DEB + 2, -1);
    chk("sim_count", count, 8);
    chk("sim_ovf", overflow, 0);
    chk("sim_dout", dout, 7'h42);
    for (int k = 0; k < 8; k++) begin
      chk("sim_drain", dout, 7'(8'h42 + k));
      pop1();
    end

    // Randomized presses, pops, clears and mid-press resets
    rnd = 1;
    for (int n = 0; n < 60; n++) begin
      len = $urandom_range(1, 14);
      ra  = -1;
      if ($urandom_range(0, 9) == 0 && len > 5) ra = $urandom_range(1, len - 3);
      press(7'($urandom), len, $urandom_range(1, 5), -1, ra);
    end
    rnd     = 0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
